// File: rtl/tri_bus_pkg.sv
// Shared encodings and width helpers for the tri-state bus arbiter.
package tri_bus_pkg;

  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] GRANT_ENC = 2'd1;
  localparam logic [1:0] TURN_ENC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = IDLE_ENC,
    GRANT = GRANT_ENC,
    TURN  = TURN_ENC
  } state_t;

  // Index width that stays at least one bit wide for degenerate counts.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_N        = 2;
  localparam int DEF_MAX_HOLD = 16;
  localparam int DEF_TURN_CYC = 1;
  localparam int DEF_OWNER_W  = $clog2(DEF_N);
  localparam int DEF_HOLD_W   = $clog2(DEF_MAX_HOLD);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import tri_bus_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [2*N-1:0] req_dbl;

  assign req_dbl = {req, req};

  // Scanning the doubled vector from ptr upward gives the wrap-around order.
  always_comb begin
    // NOTE: defaults first so every path assigns found/idx and no latch is inferred.
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!found && req_dbl[i] && (i >= int'(ptr))) begin
        found = 1'b1;
        idx   = W'((i < N) ? i : i - N);
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter driving one-hot tri-state enables with a turnaround gap
// between owners and forced release after MAX_HOLD cycles.
module tri_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int TURN_CYC = DEF_TURN_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req,
  input  logic [N-1:0]            done,
  output logic [N-1:0]            gnt,
  output logic [$clog2(N)-1:0]    owner,
  output logic                    busy,
  output logic                    timeout
);

  localparam int OWN_W  = $clog2(N);
  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam int TURN_W = idx_width(TURN_CYC);
  localparam logic [N-1:0] ONE_HOT0 = N'(1);

  state_t            state;
  logic [OWN_W-1:0]  ptr;
  logic [OWN_W-1:0]  pick_idx;
  logic              pick_found;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TURN_W-1:0] turn_cnt;

  logic owner_done;
  logic owner_req;
  logic hold_max;

  rr_pick #(
    .N (N),
    .W (OWN_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_done = done[owner];
  assign owner_req  = req[owner];
  assign hold_max   = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= GRANT;
            gnt      <= ONE_HOT0 << pick_idx;
            owner    <= pick_idx;
            busy     <= 1'b1;
            hold_cnt <= '0;
            ptr      <= (pick_idx == OWN_W'(N - 1)) ? '0 : pick_idx + 1'b1;
          end
        end
        GRANT: begin
          if (owner_done || !owner_req || hold_max) begin
            state    <= TURN;
            gnt      <= '0;
            busy     <= 1'b0;
            turn_cnt <= '0;
            // A coinciding done or withdrawal is a normal release, not a timeout.
            timeout  <= hold_max && owner_req && !owner_done;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        TURN: begin
          if (turn_cnt == TURN_W'(TURN_CYC - 1)) begin
            state <= IDLE;
          end else begin
            turn_cnt <= turn_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter plus a per-cycle invariant monitor.
module tb_tri_bus_arbiter;

  localparam int N        = 2;
  localparam int MAX_HOLD = 16;
  localparam int TURN_CYC = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] done = '0;
  logic [N-1:0] gnt;
  logic         owner;
  logic         busy;
  logic         timeout;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  logic [N-1:0] mon_prev = '0;
  int           mon_tenure = 0;

  tri_bus_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD),
    .TURN_CYC (TURN_CYC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    done = '0;
    step(1);
    rst = 1'b0;
  endtask

  // Steps until a grant appears; gap = number of all-zero cycles waited through.
  task automatic wait_grant(output int gap);
    gap = 0;
    while (gnt == '0 && gap < 20) begin
      step(1);
      gap++;
    end
    check("wait_gnt", 32'(|gnt), 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("onehot0", 32'($onehot0(gnt)), 1);
        check("busy_eq_or", 32'(busy), 32'(|gnt));
        if (gnt != '0) mon_tenure = (gnt == mon_prev) ? mon_tenure + 1 : 1;
        else           mon_tenure = 0;
        check("tenure_le_max", 32'(mon_tenure <= MAX_HOLD), 1);
        if (mon_prev != '0 && gnt != '0) check("no_adjacent_change", 32'(gnt), 32'(mon_prev));
        mon_prev = gnt;
      end
    end
  end

  initial begin
    int gap;
    int tenure;

    // Reset values
    step(2);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout", 32'(timeout), 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single request with done on the third grant cycle
    req = 2'b01;
    check("t1_latency", 32'(gnt), 0);
    step(1);
    check("t1_gnt", 32'(gnt), 32'b01);
    check("t1_owner", 32'(owner), 0);
    check("t1_busy", 32'(busy), 1);
    step(2);
    check("t1_hold", 32'(gnt), 32'b01);
    done = 2'b01;
    step(1);
    check("t1_release", 32'(gnt), 0);
    check("t1_busy_low", 32'(busy), 0);
    check("t1_no_timeout", 32'(timeout), 0);
    done = '0;
    req  = '0;
    step(1);
    check("t1_idle", 32'(gnt), 0);

    // Both requesting, done pulsed each tenure: order 0,1,0,1
    do_reset();
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_grant(gap);
      check("t2_order", 32'(gnt), (k % 2 == 0) ? 32'b01 : 32'b10);
      check("t2_owner", 32'(owner), k % 2);
      if (k > 0) check("t2_gap", gap, TURN_CYC + 1);
      done = 2'b11;
      step(1);
      done = '0;
    end
    req = '0;
    step(3);

    // Timeout: owner 0 never signals done, requester 1 pending
    do_reset();
    req = 2'b11;
    wait_grant(gap);
    check("t3_first", 32'(gnt), 32'b01);
    tenure = 1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (gnt != 2'b01) break;
      tenure++;
    end
    check("t3_tenure", tenure, MAX_HOLD);
    check("t3_timeout", 32'(timeout), 1);
    check("t3_released", 32'(gnt), 0);
    step(1);
    check("t3_timeout_pulse", 32'(timeout), 0);
    wait_grant(gap);
    check("t3_next_owner", 32'(gnt), 32'b10);
    check("t3_handoff_gap", gap, 1);
    req = '0;
    step(1);
    check("t3_withdraw_no_to", 32'(timeout), 0);

    // Early withdraw on the second grant cycle
    do_reset();
    req = 2'b01;
    wait_grant(gap);
    step(1);
    check("t4_second_cycle", 32'(gnt), 32'b01);
    req = '0;
    step(1);
    check("t4_gnt_low", 32'(gnt), 0);
    check("t4_busy_low", 32'(busy), 0);
    check("t4_no_timeout", 32'(timeout), 0);

    // Reset mid-grant, pointer returns to 0
    do_reset();
    req = 2'b11;
    wait_grant(gap);
    check("t5_pre", 32'(gnt), 32'b01);
    step(1);
    rst = 1'b1;
    step(1);
    check("t5_rst_gnt", 32'(gnt), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_owner", 32'(owner), 0);
    rst = 1'b0;
    wait_grant(gap);
    check("t5_ptr_reset", 32'(gnt), 32'b01);
    check("t5_latency", gap, 1);

    // Random traffic, invariants checked by the monitor
    req = '0;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      req  = N'($urandom);
      done = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      step(1);
    end
    req  = '0;
    done = '0;
    step(4);
    check("t6_quiet", 32'(gnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
